sm_alu_seq: RTL

- Parametrised, multi-cycle sign-and-magnitude arithmetic unit. It is the next generation of the team's combinational add/multiply/subtract calculator datapath.
- Adds a restoring divide, optional saturation, a start/busy/done handshake, and a registered remainder output.
- Sits between the operand-entry logic and the display/result formatter.
- Multiply and divide run iteratively, one bit per clock.

---
 rtl/sm_alu_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sm_alu_seq.sv
// Sign-magnitude add/sub/mul/div unit with start/busy/done handshake and registered results.
// Latency start-edge to done: 2 clocks for add/sub, WIDTH+2 for mul/div, independent of operands.
// No backpressure: start is only sampled in IDLE, results are held until the next done.
module sm_alu_seq #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [WIDTH:0]   V1,
    input  logic [WIDTH:0]   V2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   answer,
    output logic [WIDTH:0]   remainder,
    output logic             ovw
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_SEQ = CW'(WIDTH);

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        last_cnt;
    logic [1:0]           op_q;
    logic                 s1_q, s2_q;
    logic [WIDTH-1:0]     m1_q, m2_q;
    logic [2*WIDTH-1:0]   prod, mcand;
    logic [WIDTH-1:0]     mplier;      // multiplier bits, or dividend/quotient for divide
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     trial;
    logic                 trial_ok;

    logic [WIDTH+1:0]     a2, b2, sum;
    logic [WIDTH:0]       sum_mag;
    logic                 res_neg, res_ovf, rem_neg;
    logic [WIDTH-1:0]     res_low, ans_mag, rem_mag;
    logic [WIDTH:0]       res_ans, res_rem;

    assign busy     = (state != S_IDLE);
    // mul/div spend WIDTH iteration cycles plus one settle cycle in RUN
    assign last_cnt = op_q[0] ? LAST_SEQ : '0;
    assign rem_sh   = {rem_q, mplier[WIDTH-1]};
    assign trial    = {1'b0, rem_sh} - {2'b00, m2_q};
    assign trial_ok = ~trial[WIDTH+1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= OP_ADD;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            m1_q      <= '0;
            m2_q      <= '0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem_q     <= '0;
            done      <= 1'b0;
            answer    <= '0;
            remainder <= '0;
            ovw       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        cnt    <= '0;
                        op_q   <= opcode;
                        s1_q   <= V1[WIDTH] & (|V1[WIDTH-1:0]);
                        s2_q   <= V2[WIDTH] & (|V2[WIDTH-1:0]);
                        m1_q   <= V1[WIDTH-1:0];
                        m2_q   <= V2[WIDTH-1:0];
                        prod   <= '0;
                        mcand  <= {{WIDTH{1'b0}}, V1[WIDTH-1:0]};
                        mplier <= (opcode == OP_DIV) ? V1[WIDTH-1:0] : V2[WIDTH-1:0];
                        rem_q  <= '0;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt < LAST_SEQ) begin
                        if (op_q == OP_MUL) begin
                            if (mplier[0])
                                prod <= prod + mcand;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                        end else if (op_q == OP_DIV) begin
                            rem_q  <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                            mplier <= {mplier[WIDTH-2:0], trial_ok};
                        end
                    end
                    if (cnt == last_cnt)
                        state <= S_FIN;
                end
                S_FIN: begin
                    state     <= S_IDLE;
                    done      <= 1'b1;
                    answer    <= res_ans;
                    remainder <= res_rem;
                    ovw       <= res_ovf;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        a2      = s1_q ? -{2'b00, m1_q} : {2'b00, m1_q};
        b2      = s2_q ? -{2'b00, m2_q} : {2'b00, m2_q};
        sum     = (op_q == OP_ADD) ? (b2 + a2) : (b2 - a2);
        sum_mag = sum[WIDTH+1] ? -sum[WIDTH:0] : sum[WIDTH:0];
        res_neg = 1'b0;
        res_ovf = 1'b0;
        res_low = '0;
        rem_neg = 1'b0;
        rem_mag = '0;
        case (op_q)
            OP_MUL: begin
                res_neg = s1_q ^ s2_q;
                res_ovf = |prod[2*WIDTH-1:WIDTH];
                res_low = prod[WIDTH-1:0];
            end
            OP_DIV: begin
                res_neg = s1_q ^ s2_q;
                res_ovf = (m2_q == '0);
                if (!res_ovf) begin
                    res_low = mplier;
                    rem_neg = s1_q;
                    rem_mag = rem_q;
                end
            end
            default: begin
                res_neg = sum[WIDTH+1];
                res_ovf = sum_mag[WIDTH];
                res_low = sum_mag[WIDTH-1:0];
            end
        endcase
        // divide-by-zero reports zero, never the clamp value
        ans_mag = (res_ovf && SATURATE && (op_q != OP_DIV)) ? '1 : res_low;
        res_ans = {res_neg & (|ans_mag), ans_mag};
        res_rem = {rem_neg & (|rem_mag), rem_mag};
    end

endmodule
